// File: rtl/fetch_pkg.sv
// Shared parameters and entry types for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000;
  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from the storage registers.
// Push is accepted when not full or when a pop frees the slot in the same cycle; flush wins over push.
module fetch_fifo #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: sequential PC, in-order imem requests, small queue to decode.
// Response at N+L for a request at N, instruction visible at N+L+1; requests stall at FQ_DEPTH in flight plus buffered.
module ifetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter int FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst_data
);
  localparam int CW = $clog2(FQ_DEPTH+1);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding, drop_cnt, fq_count, pcq_count;
  logic [CW:0]     occupancy;
  logic            req_fire, rsp_drop, fq_push, inst_pop;
  logic            pcq_empty, pcq_full, fq_empty, fq_full;
  logic [XLEN-1:0] rsp_pc;
  fetch_entry_t    fq_in, fq_head;

  assign occupancy      = {1'b0, outstanding} + {1'b0, fq_count};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (redirect_valid || drop_cnt != '0);
  assign fq_push  = imem_rsp_valid && !rsp_drop;
  assign fq_in    = '{pc: rsp_pc, insn: imem_rsp_data};

  assign inst_valid = !rst && !fq_empty;
  assign inst_pop   = inst_valid && inst_ready;
  assign inst_pc    = rst ? '0 : fq_head.pc;
  assign inst_data  = rst ? '0 : fq_head.insn;

  fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(FQ_DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .head      (rsp_pc),
    .empty     (pcq_empty),
    .full      (pcq_full),
    .count     (pcq_count)
  );

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(FQ_DEPTH)) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fq_push),
    .push_data (fq_in),
    .pop       (inst_pop),
    .head      (fq_head),
    .empty     (fq_empty),
    .full      (fq_full),
    .count     (fq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_valid)
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)
        fetch_pc <= fetch_pc + XLEN'(INSN_BYTES);

      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

      // Everything still in flight after a redirect is stale, including requests
      // already marked for dropping, so the count restarts from the in-flight total.
      if (redirect_valid)
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (occupancy <= (CW+1)'(FQ_DEPTH));
      assert (pcq_count == outstanding);
      assert (!(imem_rsp_valid && pcq_empty));
      assert (!(req_fire && pcq_full && !imem_rsp_valid));
      assert (!(fq_push && fq_full && !inst_pop));
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order, fixed-latency instruction memory model.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pending[$];
  logic [31:0] reqs[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_data[$];
  int cyc = 0;
  int lat = 1;
  int bufcnt = 0;
  bit rand_ready = 0;
  bit occ_check = 0;
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: present due responses, record handshakes, advance to the next negedge.
  task automatic tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(pending[0].addr);
    end
    if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
    #1;
    if (occ_check) chk("occupancy_cap", 32'(imem_req_valid && (pending.size() + bufcnt >= 2)), 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      pending.push_back('{addr: imem_req_addr, due: cyc + lat});
      reqs.push_back(imem_req_addr);
    end
    if (imem_rsp_valid) begin
      void'(pending.pop_front());
      bufcnt++;
    end
    if (inst_valid && inst_ready) begin
      obs_pc.push_back(inst_pc);
      obs_data.push_back(inst_data);
      bufcnt--;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    redirect_valid = 1'b0;
    pending.delete();
    reqs.delete();
    obs_pc.delete();
    obs_data.delete();
    bufcnt = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k = 0;
    while (obs_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 32'(obs_pc.size() >= n), 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] start, input int n);
    logic [31:0] p = start;
    for (int i = 0; i < n; i++) begin
      logic [31:0] op = 'x;
      logic [31:0] od = 'x;
      if (obs_pc.size() > 0) begin
        op = obs_pc.pop_front();
        od = obs_data.pop_front();
      end
      chk({tag, "_pc"}, op, p);
      chk({tag, "_data"}, od, memword(p));
      p = p + 32'd4;
    end
  endtask

  initial begin
    // Reset values before any clock edge
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);

    // Basic sequential fetch, L=1
    lat = 1;
    reset_dut();
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    run_until("basic", 3, 50);
    check_stream("basic", 32'h8000_0000, 3);

    // Decode stall: exactly FQ_DEPTH requests, head held
    reset_dut();
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_req_count", 32'(reqs.size()), 32'd2);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);
    chk("stall_inst_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    run_until("stall", 5, 50);
    check_stream("stall", 32'h8000_0000, 5);

    // Random memory back-pressure, L=3
    lat = 3;
    reset_dut();
    rand_ready = 1;
    occ_check = 1;
    run_until("rand", 8, 300);
    rand_ready = 0;
    occ_check = 0;
    imem_req_ready = 1'b1;
    check_stream("rand", 32'h8000_0000, 8);

    // Redirect with two requests in flight, L=3
    reset_dut();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    #1;
    chk("redir_inflight_reqs", 32'(reqs.size()), 32'd2);
    chk("redir_cycle_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    run_until("redir", 3, 60);
    chk("redir_first_new_req", (reqs.size() > 2) ? reqs[2] : 32'hxxxx_xxxx, 32'h8000_0100);
    check_stream("redir", 32'h8000_0100, 3);

    // Redirect coinciding with a response and a decode handshake, L=1
    lat = 1;
    reset_dut();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    #1;
    chk("coinc_setup", 32'(inst_valid && imem_rsp_valid), 32'd1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("coinc_next_req_addr", imem_req_addr, 32'h8000_0200);
    chk("coinc_next_req_valid", 32'(imem_req_valid), 32'd1);
    run_until("coinc", 4, 50);
    check_stream("coinc_old", 32'h8000_0000, 1);
    check_stream("coinc_new", 32'h8000_0200, 3);

    // Address wrap, then reset mid-stream
    reset_dut();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    run_until("wrap", 2, 50);
    check_stream("wrap_a", 32'hFFFF_FFFC, 1);
    check_stream("wrap_b", 32'h0000_0000, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_inst_pc", inst_pc, 32'd0);
    chk("midrst_inst_data", inst_data, 32'd0);
    reset_dut();
    #1;
    chk("restart_req_addr", imem_req_addr, 32'h8000_0000);
    run_until("restart", 2, 50);
    check_stream("restart", 32'h8000_0000, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
